pkt_router_rx: RTL and testbench



---
 rtl/router_pkg.sv | 35 +++
 rtl/pkt_store_buf.sv | 52 +++++
 rtl/pkt_router_rx.sv | 151 +++++++++++++++
 tb/tb_pkt_router_rx.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types, constants and the destination-to-port decoder for the router input stage.
package router_pkg;

  typedef enum logic [2:0] {
    S_SRC,
    S_DST,
    S_SIZE,
    S_DATA,
    S_CRC,
    S_FWD
  } state_t;

  localparam int HDR_LEN = 4;
  localparam int DEF_TRUSTED_MAX = 2;
  localparam logic [15:0] DEF_PORT_LIMITS = {8'd196, 8'd128};
  localparam int LIM_W = 256;

  // First port whose exclusive upper bound exceeds dst; the last port catches everything above.
  function automatic int port_sel(input logic [LIM_W-1:0] dst,
                                  input logic [LIM_W-1:0] limits,
                                  input int num_ports,
                                  input int data_w);
    logic [LIM_W-1:0] mask;
    logic [LIM_W-1:0] lim;
    int sel;
    mask = (LIM_W'(1) << data_w) - LIM_W'(1);
    sel  = num_ports - 1;
    for (int i = num_ports - 2; i >= 0; i--) begin
      lim = (limits >> (i * data_w)) & mask;
      if (dst < lim) sel = i;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pkt_store_buf.sv
// Whole-packet store: bytes are written in arrival order and read back in the same order.
module pkt_store_buf
  import router_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SIZE_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic              wr_clr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_adv_i,
  input  logic              rd_clr_i,
  input  logic [SIZE_W-1:0] len_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_last_o
);

  localparam int DEPTH = 2**SIZE_W + HDR_LEN - 1;
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;

  // The final byte of a packet is written on the same edge that rewinds the write pointer.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_clr_i)     wr_ptr_d = '0;
    else if (wr_en_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_clr_i)      rd_ptr_d = '0;
    else if (rd_adv_i) rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign rd_last_o = (rd_ptr_q == (PTR_W'(len_i) + PTR_W'(HDR_LEN - 1)));

endmodule

// File: rtl/pkt_router_rx.sv
// Store-and-forward router input stage: receive, vet (trust + XOR checksum), then copy to one FIFO.
module pkt_router_rx
  import router_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int NUM_PORTS   = 3,
  parameter int SIZE_W      = 3,
  parameter int TRUSTED_MAX = DEF_TRUSTED_MAX,
  parameter logic [(NUM_PORTS-1)*DATA_W-1:0] PORT_LIMITS = DEF_PORT_LIMITS,
  parameter bit CRC_EN      = 1'b1
) (
  input  logic                 clk1,
  input  logic                 rst,
  input  logic                 pkt_valid,
  input  logic [DATA_W-1:0]    pkt_data,
  output logic                 in_ready,
  input  logic [NUM_PORTS-1:0] wfull,
  output logic [NUM_PORTS-1:0] winc,
  output logic [DATA_W-1:0]    wdata,
  output logic                 pkt_done,
  output logic                 drop_untrusted,
  output logic                 drop_crc
);

  localparam int PORT_W = $clog2(NUM_PORTS);
  localparam logic [DATA_W-1:0] TRUST_LIM = DATA_W'(TRUSTED_MAX);

  state_t            state_q, state_d;
  logic [SIZE_W-1:0] cnt_q, cnt_d;
  logic [SIZE_W-1:0] len_q, len_d;
  logic [DATA_W-1:0] xor_q, xor_d;
  logic              trusted_q, trusted_d;
  logic [PORT_W-1:0] port_q, port_d;
  logic              pkt_done_q, pkt_done_d;
  logic              drop_u_q, drop_u_d;
  logic              drop_c_q, drop_c_d;

  logic accept;
  logic crc_ok;
  logic fwd_wr;
  logic wr_clr;
  logic rd_last;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    xor_d      = xor_q;
    trusted_d  = trusted_q;
    port_d     = port_q;
    pkt_done_d = 1'b0;
    drop_u_d   = 1'b0;
    drop_c_d   = 1'b0;
    winc       = '0;
    fwd_wr     = 1'b0;
    wr_clr     = 1'b0;
    in_ready   = (state_q != S_FWD);
    accept     = pkt_valid && in_ready;
    crc_ok     = !CRC_EN || (xor_q == pkt_data);

    if (accept && state_q != S_CRC) xor_d = xor_q ^ pkt_data;

    case (state_q)
      S_SRC: if (accept) begin
        trusted_d = (pkt_data <= TRUST_LIM);
        state_d   = S_DST;
      end
      S_DST: if (accept) begin
        port_d  = PORT_W'(port_sel(LIM_W'(pkt_data), LIM_W'(PORT_LIMITS), NUM_PORTS, DATA_W));
        state_d = S_SIZE;
      end
      S_SIZE: if (accept) begin
        len_d   = pkt_data[SIZE_W-1:0];
        cnt_d   = pkt_data[SIZE_W-1:0];
        state_d = (pkt_data[SIZE_W-1:0] == '0) ? S_CRC : S_DATA;
      end
      S_DATA: if (accept) begin
        cnt_d = cnt_q - SIZE_W'(1);
        if (cnt_q == SIZE_W'(1)) state_d = S_CRC;
      end
      // Untrusted wins over a bad checksum so a packet never raises both drop pulses.
      S_CRC: if (accept) begin
        xor_d  = '0;
        wr_clr = 1'b1;
        if (!trusted_q) begin
          drop_u_d = 1'b1;
          state_d  = S_SRC;
        end else if (!crc_ok) begin
          drop_c_d = 1'b1;
          state_d  = S_SRC;
        end else begin
          state_d = S_FWD;
        end
      end
      S_FWD: begin
        fwd_wr       = !wfull[port_q];
        winc[port_q] = fwd_wr;
        if (fwd_wr && rd_last) begin
          state_d    = S_SRC;
          pkt_done_d = 1'b1;
        end
      end
      default: state_d = S_SRC;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q    <= S_SRC;
      cnt_q      <= '0;
      len_q      <= '0;
      xor_q      <= '0;
      trusted_q  <= 1'b0;
      port_q     <= '0;
      pkt_done_q <= 1'b0;
      drop_u_q   <= 1'b0;
      drop_c_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      xor_q      <= xor_d;
      trusted_q  <= trusted_d;
      port_q     <= port_d;
      pkt_done_q <= pkt_done_d;
      drop_u_q   <= drop_u_d;
      drop_c_q   <= drop_c_d;
    end
  end

  pkt_store_buf #(
    .DATA_W (DATA_W),
    .SIZE_W (SIZE_W)
  ) u_buf (
    .clk_i     (clk1),
    .rst_i     (rst),
    .wr_en_i   (accept),
    .wr_clr_i  (wr_clr),
    .wr_data_i (pkt_data),
    .rd_adv_i  (fwd_wr),
    .rd_clr_i  (fwd_wr && rd_last),
    .len_i     (len_q),
    .rd_data_o (wdata),
    .rd_last_o (rd_last)
  );

  assign pkt_done       = pkt_done_q;
  assign drop_untrusted = drop_u_q;
  assign drop_crc       = drop_c_q;

endmodule

// File: tb/tb_pkt_router_rx.sv
// Directed bench for pkt_router_rx: vector table of single packets plus multi-cycle sequences.
module tb_pkt_router_rx;

  logic       clk1 = 1'b0;
  logic       rst;
  logic       pkt_valid;
  logic [7:0] pkt_data;
  logic [2:0] wfull;
  logic       useNc;

  logic       valid0, valid1;
  logic       inReady0, inReady1, done0, done1, dropU0, dropU1, dropC0, dropC1;
  logic [2:0] winc0, winc1;
  logic [7:0] wdata0, wdata1;

  logic       curInReady, curDone, curDropU, curDropC;
  logic [2:0] curWinc;
  logic [7:0] curWdata;

  always #5 clk1 = ~clk1;

  assign valid0 = pkt_valid && !useNc;
  assign valid1 = pkt_valid && useNc;

  assign curInReady = useNc ? inReady1 : inReady0;
  assign curWinc    = useNc ? winc1    : winc0;
  assign curWdata   = useNc ? wdata1   : wdata0;
  assign curDone    = useNc ? done1    : done0;
  assign curDropU   = useNc ? dropU1   : dropU0;
  assign curDropC   = useNc ? dropC1   : dropC0;

  pkt_router_rx #(.CRC_EN(1'b1)) dut0 (
    .clk1(clk1), .rst(rst), .pkt_valid(valid0), .pkt_data(pkt_data), .in_ready(inReady0),
    .wfull(wfull), .winc(winc0), .wdata(wdata0), .pkt_done(done0),
    .drop_untrusted(dropU0), .drop_crc(dropC0));

  pkt_router_rx #(.CRC_EN(1'b0)) dut1 (
    .clk1(clk1), .rst(rst), .pkt_valid(valid1), .pkt_data(pkt_data), .in_ready(inReady1),
    .wfull(wfull), .winc(winc1), .wdata(wdata1), .pkt_done(done1),
    .drop_untrusted(dropU1), .drop_crc(dropC1));

  typedef struct packed {
    logic [15:0][7:0] bytes;
    logic [4:0]       n;
    logic             useNc;
    logic [2:0]       wfullv;
    logic [1:0]       expPort;
    logic [1:0]       expKind;
  } vec_t;

  typedef struct packed {
    logic [2:0] winc;
    logic [7:0] data;
  } wr_t;

  int  nCompared = 0;
  int  nMismatched = 0;
  wr_t wrQ[$];
  wr_t expQ[$];
  int  doneCnt, dropUCnt, dropCCnt, irLow;
  bit  monEn = 1'b0;
  vec_t vecs[10];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic vec_t mkVec(input logic [127:0] raw, input int n, input logic nc,
                                 input logic [2:0] wf, input logic [1:0] port, input logic [1:0] kind);
    vec_t v;
    v = '0;
    for (int i = 0; i < n; i++) v.bytes[i] = raw[(n-1-i)*8 +: 8];
    v.n = 5'(n);
    v.useNc = nc;
    v.wfullv = wf;
    v.expPort = port;
    v.expKind = kind;
    return v;
  endfunction

  // Scoreboard: capture every FIFO write and pulse, sampled on the falling edge.
  always @(negedge clk1) begin
    if (monEn) begin
      if (curWinc != 3'b000) wrQ.push_back({curWinc, curWdata});
      if (curDone)  doneCnt++;
      if (curDropU) dropUCnt++;
      if (curDropC) dropCCnt++;
      if (!curInReady) irLow++;
      check("winc onehot0", 32'($onehot0(curWinc)), 32'd1);
    end
  end

  task automatic clearMon();
    wrQ.delete();
    expQ.delete();
    doneCnt = 0;
    dropUCnt = 0;
    dropCCnt = 0;
    irLow = 0;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the byte.
  task automatic sendByte(input logic [7:0] b, input int gapMax);
    int g;
    bit ok;
    g = (gapMax > 0) ? int'($urandom_range(gapMax, 0)) : 0;
    repeat (g) begin @(posedge clk1); #1; end
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (curInReady) begin ok = 1'b1; break; end
      @(posedge clk1); #1;
    end
    if (!ok) check("in_ready timeout", 32'd0, 32'd1);
    pkt_valid = 1'b1;
    pkt_data  = b;
    @(posedge clk1); #1;
    pkt_valid = 1'b0;
  endtask

  task automatic waitOutcome(input int need);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk1);
      if (doneCnt + dropUCnt + dropCCnt >= need) begin ok = 1'b1; break; end
    end
    if (!ok) check("outcome timeout", 32'd0, 32'd1);
    repeat (4) @(negedge clk1);
    @(posedge clk1); #1;
  endtask

  task automatic sendPkt(input logic [127:0] raw, input int n, input int gapMax);
    for (int i = 0; i < n; i++) sendByte(raw[(n-1-i)*8 +: 8], gapMax);
  endtask

  task automatic pushExp(input logic [127:0] raw, input int n, input logic [2:0] w);
    for (int i = 0; i < n; i++) expQ.push_back({w, raw[(n-1-i)*8 +: 8]});
  endtask

  task automatic compareWrites(input string tag);
    int m;
    check({tag, " nWrites"}, 32'(wrQ.size()), 32'(expQ.size()));
    m = (wrQ.size() < expQ.size()) ? wrQ.size() : expQ.size();
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s w%0d winc", tag, i), 32'(wrQ[i].winc), 32'(expQ[i].winc));
      check($sformatf("%s w%0d wdata", tag, i), 32'(wrQ[i].data), 32'(expQ[i].data));
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    clearMon();
    useNc = v.useNc;
    wfull = v.wfullv;
    for (int i = 0; i < int'(v.n); i++) sendByte(v.bytes[i], 0);
    waitOutcome(1);
    wfull = 3'b000;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    if (v.expKind == 2'd0)
      for (int i = 0; i < int'(v.n); i++) expQ.push_back({3'(1 << v.expPort), v.bytes[i]});
    compareWrites(tag);
    check({tag, " pkt_done"}, 32'(doneCnt), (v.expKind == 2'd0) ? 32'd1 : 32'd0);
    check({tag, " drop_untrusted"}, 32'(dropUCnt), (v.expKind == 2'd1) ? 32'd1 : 32'd0);
    check({tag, " drop_crc"}, 32'(dropCCnt), (v.expKind == 2'd2) ? 32'd1 : 32'd0);
    check({tag, " in_ready low"}, 32'(irLow), (v.expKind == 2'd0) ? 32'(v.n) : 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    pkt_valid = 1'b0;
    pkt_data = 8'h00;
    wfull = 3'b000;
    useNc = 1'b0;

    // kind: 0 forward, 1 untrusted drop, 2 checksum drop
    vecs[0] = mkVec(128'h01_10_02_A5_3C_8A, 6, 1'b0, 3'b000, 2'd0, 2'd0);
    vecs[1] = mkVec(128'h07_10_02_A5_3C_8C, 6, 1'b0, 3'b000, 2'd0, 2'd1);
    vecs[2] = mkVec(128'h01_10_02_A5_3C_8B, 6, 1'b0, 3'b000, 2'd0, 2'd2);
    vecs[3] = mkVec(128'h01_10_02_A5_3C_8B, 6, 1'b1, 3'b000, 2'd0, 2'd0);
    vecs[4] = mkVec(128'h00_C4_00_C4,       4, 1'b0, 3'b000, 2'd2, 2'd0);
    vecs[5] = mkVec(128'h00_C3_00_C3,       4, 1'b0, 3'b101, 2'd1, 2'd0);
    vecs[6] = mkVec(128'h01_10_0A_A5_3C_82, 6, 1'b0, 3'b000, 2'd0, 2'd0);
    vecs[7] = mkVec(128'h05_10_00_00,       4, 1'b0, 3'b000, 2'd0, 2'd1);
    vecs[8] = mkVec(128'h02_7F_00_7D,       4, 1'b0, 3'b000, 2'd0, 2'd0);
    vecs[9] = mkVec(128'h00_80_00_80,       4, 1'b0, 3'b000, 2'd1, 2'd0);

    repeat (2) @(posedge clk1);
    #1 rst = 1'b0;
    @(negedge clk1);
    check("reset in_ready0", 32'(inReady0), 32'd1);
    check("reset winc0", 32'(winc0), 32'd0);
    check("reset pulses0", 32'({done0, dropU0, dropC0}), 32'd0);
    check("reset in_ready1", 32'(inReady1), 32'd1);
    check("reset winc1", 32'(winc1), 32'd0);
    @(posedge clk1); #1;
    monEn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end
    useNc = 1'b0;

    // Three-cycle backpressure on port 2 while its packet is being forwarded.
    clearMon();
    sendPkt(128'h00_C4_00_C4, 4, 0);
    @(posedge clk1); #1;
    wfull = 3'b100;
    repeat (3) begin @(posedge clk1); #1; end
    wfull = 3'b000;
    waitOutcome(1);
    pushExp(128'h00_C4_00_C4, 4, 3'b100);
    compareWrites("stall");
    check("stall in_ready low", 32'(irLow), 32'd7);
    check("stall pkt_done", 32'(doneCnt), 32'd1);

    // Back-to-back maximum-size packets with random gaps on the link.
    clearMon();
    sendPkt(128'h02_05_07_11_12_13_14_15_16_17_10, 11, 3);
    sendPkt(128'h00_B0_07_01_02_03_04_05_06_07_B7, 11, 3);
    waitOutcome(2);
    pushExp(128'h02_05_07_11_12_13_14_15_16_17_10, 11, 3'b001);
    pushExp(128'h00_B0_07_01_02_03_04_05_06_07_B7, 11, 3'b010);
    compareWrites("b2b");
    check("b2b in_ready low", 32'(irLow), 32'd22);
    check("b2b pkt_done", 32'(doneCnt), 32'd2);
    check("b2b drops", 32'(dropUCnt + dropCCnt), 32'd0);

    // Reset while receiving payload, then a clean packet.
    clearMon();
    sendPkt(128'h02_05_07_11_12, 5, 0);
    rst = 1'b1;
    @(posedge clk1); #1;
    rst = 1'b0;
    sendPkt(128'h02_05_07_11_12_13_14_15_16_17_10, 11, 0);
    waitOutcome(1);
    pushExp(128'h02_05_07_11_12_13_14_15_16_17_10, 11, 3'b001);
    compareWrites("rst");
    check("rst pkt_done", 32'(doneCnt), 32'd1);
    check("rst drops", 32'(dropUCnt + dropCCnt), 32'd0);

    monEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
